// File: rtl/alu_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_operand_stage: single-entry operand capture stage with EX/MEM and MEM/WB forwarding. Rev 1.0
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [4:0]   rs1_addr_i,
  input  logic [4:0]   rs2_addr_i,
  input  logic [4:0]   rd_addr_i,
  input  logic [N-1:0] rs1_data_i,
  input  logic [N-1:0] rs2_data_i,
  input  logic [N-1:0] imm_i,
  input  logic         use_imm_i,
  input  logic [3:0]   op_in_i,
  input  logic         reg_write_in_i,
  input  logic [4:0]   exmem_rd_i,
  input  logic         exmem_we_i,
  input  logic [N-1:0] exmem_result_i,
  input  logic [4:0]   memwb_rd_i,
  input  logic         memwb_we_i,
  input  logic [N-1:0] memwb_result_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [3:0]   alu_op_o,
  output logic [4:0]   out_rd_o,
  output logic         out_reg_write_o,
  output logic         out_illegal_o,
  output logic [15:0]  stall_cnt_o
);

  logic         valid_q, valid_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic [4:0]   rd_q, rd_d, rs1a_q, rs1a_d, rs2a_q, rs2a_d;
  logic         we_q, we_d, ill_q, ill_d, imm_sel_q, imm_sel_d;
  logic [15:0]  stall_q, stall_d;
  logic         capture;
  logic         op_legal;

  // EX/MEM has priority over MEM/WB; x0 is never forwarded.
  function automatic logic [N-1:0] fwd(input logic [4:0] addr, input logic [N-1:0] dflt);
    if (addr != 5'd0 && exmem_we_i && exmem_rd_i == addr)      return exmem_result_i;
    else if (addr != 5'd0 && memwb_we_i && memwb_rd_i == addr) return memwb_result_i;
    else                                                       return dflt;
  endfunction

  always_comb begin
    case (op_in_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b1100,
      4'b0011, 4'b1010, 4'b1110, 4'b0111: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign capture    = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1a_d    = rs1a_q;
    rs2a_d    = rs2a_q;
    we_d      = we_q;
    ill_d     = ill_q;
    imm_sel_d = imm_sel_q;
    stall_d   = (valid_q && !out_ready_i && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      rs1a_d    = rs1_addr_i;
      rs2a_d    = rs2_addr_i;
      imm_sel_d = use_imm_i;
      a_d       = fwd(rs1_addr_i, rs1_data_i);
      b_d       = use_imm_i ? imm_i : fwd(rs2_addr_i, rs2_data_i);
      op_d      = op_legal ? op_in_i : 4'b0000;
      ill_d     = !op_legal;
      we_d      = reg_write_in_i && op_legal && (rd_addr_i != 5'd0);
      rd_d      = rd_addr_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: keep picking up late results for the held source registers.
      a_d = fwd(rs1a_q, a_q);
      if (!imm_sel_q) b_d = fwd(rs2a_q, b_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 4'b0000;
      rd_q      <= 5'd0;
      rs1a_q    <= 5'd0;
      rs2a_q    <= 5'd0;
      we_q      <= 1'b0;
      ill_q     <= 1'b0;
      imm_sel_q <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1a_q    <= rs1a_d;
      rs2a_q    <= rs2a_d;
      we_q      <= we_d;
      ill_q     <= ill_d;
      imm_sel_q <= imm_sel_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid_o     = valid_q;
  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;
  assign alu_op_o        = op_q;
  assign out_rd_o        = rd_q;
  assign out_reg_write_o = we_q;
  assign out_illegal_o   = ill_q;
  assign stall_cnt_o     = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_operand_stage: directed vectors against a behavioural model of the operand stage. Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, use_imm, reg_write_in, exmem_we, memwb_we, flush;
  logic out_valid, out_ready, out_reg_write, out_illegal;
  logic [4:0] rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, out_rd;
  logic [N-1:0] rs1_data, rs2_data, imm, exmem_result, memwb_result, alu_a, alu_b;
  logic [3:0] op_in, alu_op;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .imm_i(imm), .use_imm_i(use_imm),
    .op_in_i(op_in), .reg_write_in_i(reg_write_in),
    .exmem_rd_i(exmem_rd), .exmem_we_i(exmem_we), .exmem_result_i(exmem_result),
    .memwb_rd_i(memwb_rd), .memwb_we_i(memwb_we), .memwb_result_i(memwb_result),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .out_rd_o(out_rd), .out_reg_write_o(out_reg_write), .out_illegal_o(out_illegal),
    .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] legal_codes [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b1100,
                                  4'b0011, 4'b1010, 4'b1110, 4'b0111};
  logic         m_valid;
  logic [N-1:0] m_a, m_b;
  logic [3:0]   m_op;
  logic [4:0]   m_rd, m_rs1, m_rs2;
  logic         m_we, m_ill, m_imm;
  int           m_stall;

  function automatic logic [N-1:0] newest(input logic [4:0] r, input logic [N-1:0] old);
    logic [N-1:0] v;
    v = old;
    if (r != 0 && memwb_we && memwb_rd == r) v = memwb_result;
    if (r != 0 && exmem_we && exmem_rd == r) v = exmem_result;
    return v;
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    foreach (legal_codes[i]) if (legal_codes[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_we = 0; m_ill = 0;
      m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_stall = 0;
    end else begin
      bit take;
      if (m_valid && !out_ready) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      take = in_valid && !flush && (!m_valid || out_ready);
      if (flush) m_valid = 0;
      else if (take) begin
        m_valid = 1;
        m_rs1 = rs1_addr; m_rs2 = rs2_addr; m_imm = use_imm; m_rd = rd_addr;
        m_a = newest(rs1_addr, rs1_data);
        m_b = use_imm ? imm : newest(rs2_addr, rs2_data);
        m_ill = !is_legal(op_in);
        m_op = m_ill ? 4'b0000 : op_in;
        m_we = reg_write_in && !m_ill && rd_addr != 0;
      end else if (m_valid && out_ready) m_valid = 0;
      else if (m_valid) begin
        m_a = newest(m_rs1, m_a);
        if (!m_imm) m_b = newest(m_rs2, m_b);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", N'(out_valid), N'(m_valid));
      check("in_ready", N'(in_ready), N'(!m_valid || out_ready));
      check("stall_cnt", N'(stall_cnt), N'(m_stall));
      if (m_valid) begin
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_op", N'(alu_op), N'(m_op));
        check("out_rd", N'(out_rd), N'(m_rd));
        check("out_reg_write", N'(out_reg_write), N'(m_we));
        check("out_illegal", N'(out_illegal), N'(m_ill));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(); @(negedge clk); #1; endtask

  task automatic instr(input logic [4:0] r1, input logic [N-1:0] d1, input logic [4:0] r2,
                       input logic [N-1:0] d2, input logic [3:0] op, input logic [4:0] rd,
                       input logic wr, input logic ui, input logic [N-1:0] im);
    in_valid = 1; rs1_addr = r1; rs1_data = d1; rs2_addr = r2; rs2_data = d2;
    op_in = op; rd_addr = rd; reg_write_in = wr; use_imm = ui; imm = im;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; flush = 0; use_imm = 0; reg_write_in = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rs1_data = 0; rs2_data = 0; imm = 0; op_in = 0;
    exmem_rd = 0; exmem_we = 0; exmem_result = 0; memwb_rd = 0; memwb_we = 0; memwb_result = 0;
    repeat (2) cyc();
    check("rst out_valid", N'(out_valid), 0);
    check("rst alu_a", alu_a, 0);
    check("rst stall_cnt", N'(stall_cnt), 0);
    rst_n = 1;

    // ADD capture, latency one
    instr(5, 10, 6, 20, 4'b0100, 7, 1, 0, 0);
    cyc();
    in_valid = 0;
    check("add valid", N'(out_valid), 1);
    check("add a", alu_a, 10);
    check("add b", alu_b, 20);
    check("add op", N'(alu_op), N'(4'b0100));
    cyc();
    check("drain", N'(out_valid), 0);

    // dual forward: EX/MEM wins; x0 never forwarded
    exmem_we = 1; exmem_rd = 3; exmem_result = 32'hAAAA;
    memwb_we = 1; memwb_rd = 3; memwb_result = 32'h5555;
    instr(3, 1, 8, 2, 4'b1001, 9, 1, 0, 0);
    cyc();
    check("fwd exmem", alu_a, 32'hAAAA);
    exmem_rd = 0; memwb_rd = 0;
    instr(0, 32'h1234, 0, 32'h77, 4'b0010, 2, 1, 0, 0);
    cyc();
    check("fwd x0", alu_a, 32'h1234);
    // immediate bypasses forwarding of b
    exmem_rd = 4;
    instr(1, 5, 4, 6, 4'b0111, 0, 1, 1, 32'hFFFF_FFF0);
    cyc();
    check("imm b", alu_b, 32'hFFFF_FFF0);
    check("rd0 we", N'(out_reg_write), 0);
    exmem_we = 0; memwb_we = 0;

    // back-pressure with late MEM/WB result for rs2
    instr(2, 3, 9, 5, 4'b1100, 11, 1, 0, 0);
    cyc();
    in_valid = 0; out_ready = 0;
    cyc();
    check("stall in_ready", N'(in_ready), 0);
    memwb_we = 1; memwb_rd = 9; memwb_result = 77;
    cyc();
    memwb_we = 0;
    cyc();
    check("refresh b", alu_b, 77);
    check("stall 3", N'(stall_cnt), 3);
    out_ready = 1;
    cyc();

    // illegal opcode
    instr(1, 1, 2, 2, 4'b1111, 4, 1, 0, 0);
    cyc();
    in_valid = 0;
    check("ill op", N'(alu_op), 0);
    check("ill flag", N'(out_illegal), 1);
    check("ill we", N'(out_reg_write), 0);

    // flush while FULL and stalled, with a new instruction offered
    out_ready = 0;
    cyc();
    instr(6, 66, 7, 77, 4'b0100, 5, 1, 0, 0);
    flush = 1;
    cyc();
    flush = 0; in_valid = 0;
    check("flush valid", N'(out_valid), 0);

    // asynchronous reset mid-stall
    instr(6, 66, 7, 77, 4'b1110, 5, 1, 0, 0);
    cyc();
    in_valid = 0;
    repeat (2) cyc();
    rst_n = 0;
    #1;
    check("arst valid", N'(out_valid), 0);
    check("arst a", alu_a, 0);
    check("arst b", alu_b, 0);
    check("arst op", N'(alu_op), 0);
    check("arst we", N'(out_reg_write), 0);
    check("arst stall", N'(stall_cnt), 0);
    cyc();
    rst_n = 1;
    instr(1, 3, 2, 4, 4'b0001, 3, 1, 0, 0);
    cyc();
    in_valid = 0;
    check("post-rst capture", alu_a, 3);

    // stall counter saturation
    repeat (65540) cyc();
    check("stall sat", N'(stall_cnt), 32'hFFFF);
    out_ready = 1;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: N, 32, datapath width of operands and forwarded results.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  decoded instruction present from decode.
REQ-005 in_ready  out  1  stage can accept an instruction this cycle.
REQ-006 rs1_addr, rs2_addr, rd_addr  in  5 each  register indices.
REQ-007 rs1_data, rs2_data  in  N each  register-file read data.
REQ-008 imm  in  N  sign-extended immediate; use_imm  in  1  selects imm as operand b.
REQ-009 op_in  in  4  ALU operation code; reg_write_in  in  1  instruction writes rd.
REQ-010 exmem_rd  in  5, exmem_we  in  1, exmem_result  in  N  EX/MEM forwarding source.
REQ-011 memwb_rd  in  5, memwb_we  in  1, memwb_result  in  N  MEM/WB forwarding source.
REQ-012 flush  in  1  discard held/incoming instruction.
REQ-013 out_valid  out  1; out_ready  in  1  handshake to ALU/execute.
REQ-014 alu_a, alu_b  out  N; alu_op  out  4; out_rd  out  5; out_reg_write  out  1.
REQ-015 out_illegal  out  1  held op_in was not a legal ALU code.
REQ-016 stall_cnt  out  16  saturating count of back-pressure cycles.

Function
REQ-017 Legal codes: 0001 AND, 0010 OR, 0100 ADD, 1001 SUB, 1100 SLT, 0011 SLL, 1010 SRL, 1110 MUL, 0111 XOR; any other code is illegal.
REQ-018 Single-entry register stage; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 in_ready = !out_valid || out_ready (combinational pass-through when draining).
REQ-020 Capture occurs when in_valid && in_ready && !flush; stage becomes FULL next cycle (latency 1).
REQ-021 FULL to EMPTY when out_ready && !(in_valid && !flush); FULL stays FULL on simultaneous accept-out and accept-in, loading the new instruction.
REQ-022 Forwarding per operand at capture: if exmem_we && exmem_rd==rsX_addr && rsX_addr!=0 use exmem_result; else if memwb_we && memwb_rd==rsX_addr && rsX_addr!=0 use memwb_result; else rsX_data. EX/MEM wins when both match.
REQ-023 While FULL and not draining, held rs1/rs2 operands are refreshed each cycle by the same REQ-022 rule against held rs1/rs2 addresses; no match leaves value unchanged.
REQ-024 alu_b = imm when held use_imm=1 (no forwarding applied to b); else forwarded rs2 value.
REQ-025 Illegal op_in captured: alu_op=0000, out_illegal=1, out_reg_write=0; instruction still handshakes normally.
REQ-026 rd_addr==0 forces out_reg_write=0.
REQ-027 flush: next cycle out_valid=0, incoming instruction dropped regardless of in_valid/out_ready; flush has priority over capture.
REQ-028 stall_cnt increments by 1 each cycle out_valid && !out_ready; holds at 16'hFFFF.
REQ-029 Outputs alu_a, alu_b, alu_op, out_rd, out_reg_write, out_illegal stable while out_valid && !out_ready except for REQ-023 refresh of alu_a/alu_b.

Reset
REQ-030 rst_n low asynchronously forces out_valid=0, alu_a=0, alu_b=0, alu_op=0000, out_rd=0, out_reg_write=0, out_illegal=0, stall_cnt=0.
REQ-031 Instruction in flight at reset assertion is discarded; first capture is possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Capture ADD: rs1=5 data 10, rs2=6 data 20, op 0100, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=20, alu_op=0100.
REQ-033 Dual forward: rs1=3, exmem_rd=3 result 0xAAAA, memwb_rd=3 result 0x5555, both we=1 -> alu_a=0xAAAA; rs1=0 with exmem_rd=0 -> alu_a=rs1_data.
REQ-034 Back-pressure 3 cycles with memwb_rd=rs2 arriving on cycle 2 result 77 -> alu_b=77 after refresh, stall_cnt=3, in_ready=0 during stall.
REQ-035 op_in=1111, rd=4, reg_write_in=1 -> alu_op=0000, out_illegal=1, out_reg_write=0.
REQ-036 flush with in_valid=1 while FULL -> out_valid=0 next cycle, no capture; rst_n pulsed low mid-stall -> all outputs and stall_cnt zero immediately.
